// File: rtl/nn_layer_sequencer_pkg.sv
// Shared encodings for the fully-connected layer sequencer: FSM states,
// sticky error codes and bit positions within the MAC state word.
package nn_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ACK   = 3'd2,
    ST_RUN   = 3'd3,
    ST_WRITE = 3'd4,
    ST_FIN   = 3'd5,
    ST_ABORT = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_BAD_LEN    = 2'd1,
    ERR_MAC_REJECT = 2'd2,
    ERR_TIMEOUT    = 2'd3
  } seq_err_t;

  localparam int MS_FINISH    = 0;
  localparam int MS_BUS_CRASH = 3;
  localparam int MS_REQ_ERR   = 5;
  localparam int MS_EDB_BUSY  = 6;

  // The MAC refuses a start either on a request error or a bus crash.
  function automatic logic mac_rejected(input logic [7:0] ms);
    return ms[MS_REQ_ERR] | ms[MS_BUS_CRASH];
  endfunction

endpackage

// File: rtl/nn_layer_sequencer_timeout.sv
// Loadable down-counter bounding how long the MAC may take to acknowledge a
// start by dropping mac_finish; expired is high once the budget is spent.
module nn_seq_timeout #(
  parameter int TMO = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] count_reg;

  // Loaded with TMO-1 so that expiry is seen on the TMO-th decrementing cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(TMO - 1);
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Runs one fully-connected layer: per neuron it starts the MAC, waits for the
// finish handshake and stores the accumulated result at the neuron index.
module nn_layer_sequencer
  import nn_layer_sequencer_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32,
  parameter int NWIDTH = 8,
  parameter int TMO    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_start,
  input  logic [AWIDTH-1:0] n_inputs,
  input  logic [NWIDTH-1:0] n_neurons,
  output logic [AWIDTH:0]   mac_ctrl,
  input  logic [7:0]        mac_state,
  input  logic [DWIDTH-1:0] acc_result,
  output logic [NWIDTH-1:0] wpage,
  output logic              res_we,
  output logic [NWIDTH-1:0] res_addr,
  output logic [DWIDTH-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  seq_state_t        state_reg;
  seq_state_t        state_next;
  seq_err_t          err_reg;
  logic              issue_second_reg;
  logic [NWIDTH-1:0] idx_reg;
  logic [AWIDTH-1:0] n_inputs_reg;
  logic [NWIDTH-1:0] n_neurons_reg;

  logic              accept;
  logic              bad_len;
  logic              mac_reject;
  logic              mac_finish;
  logic              last_neuron;
  logic              tmo_load;
  logic              tmo_dec;
  logic              tmo_expired;
  logic [AWIDTH-1:0] loop_count;
  logic              unused_mac_bits;

  assign accept      = (state_reg == ST_IDLE) && layer_start;
  assign bad_len     = (n_inputs == '0);
  assign mac_reject  = mac_rejected(mac_state);
  assign mac_finish  = mac_state[MS_FINISH];
  assign last_neuron = (idx_reg == (n_neurons_reg - NWIDTH'(1)));
  // The MAC walks addresses 0..loop inclusive, hence one less than the length.
  assign loop_count  = n_inputs_reg - AWIDTH'(1);

  assign unused_mac_bits = ^{mac_state[7:6], mac_state[4], mac_state[2:1]};

  // Budget restarts each time a neuron's start phase begins; only ACK spends it.
  assign tmo_load = (state_next == ST_ISSUE) && (state_reg != ST_ISSUE);
  assign tmo_dec  = (state_reg == ST_ACK);

  nn_seq_timeout #(
    .TMO(TMO)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .dec     (tmo_dec),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (layer_start && !bad_len) begin
          state_next = (n_neurons == '0) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mac_reject) begin
          state_next = ST_ABORT;
        end else if (issue_second_reg) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        if (mac_reject) begin
          state_next = ST_ABORT;
        end else if (!mac_finish) begin
          state_next = ST_RUN;
        end else if (tmo_expired) begin
          state_next = ST_ABORT;
        end
      end
      ST_RUN: begin
        if (mac_finish) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_next = last_neuron ? ST_FIN : ST_ISSUE;
      end
      ST_FIN:   state_next = ST_IDLE;
      ST_ABORT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mac_ctrl = '0;
    busy     = 1'b0;
    done     = 1'b0;
    res_we   = 1'b0;
    res_addr = '0;
    res_data = '0;
    case (state_reg)
      ST_ISSUE: begin
        mac_ctrl = {loop_count, 1'b1};
        busy     = 1'b1;
      end
      ST_ACK, ST_RUN: begin
        mac_ctrl = {loop_count, 1'b0};
        busy     = 1'b1;
      end
      ST_WRITE: begin
        mac_ctrl = {loop_count, 1'b0};
        busy     = 1'b1;
        // A reset landing on the write cycle must not corrupt the buffer.
        res_we   = !rst;
        res_addr = idx_reg;
        res_data = acc_result;
      end
      ST_FIN: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_second_reg <= 1'b0;
      idx_reg          <= '0;
      n_inputs_reg     <= '0;
      n_neurons_reg    <= '0;
      err_reg          <= ERR_NONE;
    end else begin
      issue_second_reg <= (state_reg == ST_ISSUE) && (state_next == ST_ISSUE);

      if (accept) begin
        err_reg <= bad_len ? ERR_BAD_LEN : ERR_NONE;
        if (!bad_len) begin
          n_inputs_reg  <= n_inputs;
          n_neurons_reg <= n_neurons;
          idx_reg       <= '0;
        end
      end else if (((state_reg == ST_ISSUE) || (state_reg == ST_ACK)) && mac_reject) begin
        err_reg <= ERR_MAC_REJECT;
      end else if ((state_reg == ST_ACK) && mac_finish && tmo_expired) begin
        err_reg <= ERR_TIMEOUT;
      end

      // wpage returns to page 0 whenever the layer ends, normally or not.
      if (state_reg == ST_WRITE) begin
        idx_reg <= last_neuron ? '0 : idx_reg + NWIDTH'(1);
      end else if (state_reg == ST_ABORT) begin
        idx_reg <= '0;
      end
    end
  end

  assign wpage = idx_reg;
  assign err   = err_reg;

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Upstream control stage for the MAC controller. Runs one fully-connected layer.
- For each output neuron it issues a start/loop-count word on the MAC ctrl bus and waits for MAC completion.
- It then captures the accumulated float result and writes it to the layer output buffer at the neuron index.
- It advances a weight-page base so the MAC's addr_rd reads the correct weight row.

Parameters:
- AWIDTH, 8, MAC address width; matches `AWIDTH.
- DWIDTH, 32, accumulator/result data width (IEEE-754 single).
- NWIDTH, 8, neuron index width.
- TMO, 64, cycles allowed for the MAC to deassert mac_finish after a start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- layer_start  in  1  one-cycle request to run a layer
- n_inputs  in  AWIDTH  inputs per neuron (1..2^AWIDTH-1); sampled on accept
- n_neurons  in  NWIDTH  neurons in layer; sampled on accept
- mac_ctrl  out  AWIDTH+1  to MAC ctrl: bit0 start, [AWIDTH:1] loop count
- mac_state  in  8  from MAC state: bit6 edb_busy, bit5 require_error, bit3 bus_crash, bit0 mac_finish
- acc_result  in  DWIDTH  MAC accumulator output
- wpage  out  NWIDTH  current neuron index, weight-page base
- res_we  out  1  output-buffer write strobe
- res_addr  out  NWIDTH  output-buffer address
- res_data  out  DWIDTH  output-buffer data
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse, layer completed normally
- err  out  2  sticky code: 0 none, 1 bad length, 2 MAC reject, 3 timeout

Behaviour:
- Reset values: mac_ctrl=0, wpage=0, res_we=0, res_addr=0, res_data=0, busy=0, done=0, err=0, state IDLE.
- Reset mid-operation aborts immediately. No write is issued in the reset cycle.
- Sampling rule: n_inputs and n_neurons are sampled only when layer_start is accepted.
- IDLE: on layer_start, check lengths.
  - n_inputs==0 -> err=1, done not pulsed, stay IDLE.
  - n_neurons==0 -> done pulse next cycle, err=0.
  - Otherwise latch the lengths, clear err, set busy=1, idx=0, go ISSUE.
  - layer_start while busy is ignored.
- ISSUE (2 cycles): mac_ctrl={n_inputs-1, 1'b1} held for exactly 2 cycles.
  - This is the MAC's minimum start-hold requirement.
  - The loop field is n_inputs-1 because the MAC reads addresses 0..loop inclusive.
  - Then drive mac_ctrl bit0=0, loop field held. Go ACK.
- ACK: wait for mac_state[0]==0, then go RUN.
  - mac_state[5] or mac_state[3] seen in ISSUE/ACK -> err=2, go ABORT.
  - TMO cycles elapsed in ACK without mac_finish falling -> err=3, go ABORT.
- RUN: wait for mac_state[0]==1. No timeout in this state; MAC latency scales with n_inputs. Then go WRITE.
- WRITE (1 cycle): res_we=1, res_addr=idx, res_data=acc_result sampled this cycle.
  - idx==n_neurons-1 -> go FIN.
  - Else idx+1, wpage=idx+1, go ISSUE. Back-to-back is legal because bit0 was low since ISSUE end.
- FIN: done=1 for one cycle, busy=0, wpage=0, go IDLE.
- ABORT: mac_ctrl=0, busy=0, no done pulse, go IDLE. err stays until next accepted layer_start or rst.
- wpage always equals idx while busy.
- idx never wraps: n_neurons=2^NWIDTH-1 is the maximum.
- Latency per neuron: 2 ISSUE cycles + ACK wait + MAC run + 1 WRITE.

Decomposition:
- Shared header extern.v (alongside `AWIDTH, `CELL_N) holds:
  - state encodings
  - err codes
  - mac_state bit positions (FINISH=0, BUS_CRASH=3, REQ_ERR=5, EDB_BUSY=6)
- One natural sub-module: nn_seq_timeout. Loadable down-counter, width clog2(TMO+1); load on ISSUE entry, expire flag.

Test Plan:
- Nominal: n_inputs=4, n_neurons=3; MAC model drops finish 2 cycles after start rise, raises it 10 cycles later with acc_result=0x3F800000+idx.
  -> 3 writes to addr 0,1,2 with data 0x3F800000, 0x3F800001, 0x3F800002.
  -> mac_ctrl loop field=3 and bit0 high exactly 2 cycles per neuron; done pulse once; err=0.
- Zero-length: n_inputs=0 -> err=1, no mac_ctrl activity, no done. Then n_neurons=0 with n_inputs=5 -> done 1 cycle later, no writes.
- MAC reject: assert mac_state[5] during 2nd ISSUE cycle of neuron 1 -> err=2, busy falls, mac_ctrl=0, only addr 0 written.
- Timeout: MAC model never drops finish -> after 64 ACK cycles err=3, no write, no done.
- Reset mid-RUN at neuron 2 of 4: -> all outputs at reset values next cycle. A new layer_start then runs cleanly from idx 0.
- Ignore start while busy: pulse layer_start during RUN of neuron 0 with n_neurons=1 -> exactly 1 write and 1 done.
